// File: rtl/writeback_unit_if.sv
// Writeback-stage bundle: MEM/WB result fields, decode read ports, status outputs.
// Latency: none; this is a passive signal bundle.
// Backpressure: none; writeback always accepts what MEM/WB presents.
// Ports (bundle members):
//   MEM/WB : inst_addr_wb, ALU_result_wb, mem_addr_wb, rd_num_wb, register_src_wb,
//            register_write_wb, is_word_wb, cache_data_out_wb, byte_number_wb,
//            halted_controller_wb
//   decode : rs_num, rt_num -> rs_data, rt_data
//   status : halted, write_count, last_commit_pc
// modport master drives the pipeline/decode side; modport slave is the writeback unit.
interface writeback_unit_if;
    logic [31:0]      inst_addr_wb;
    logic [31:0]      ALU_result_wb;
    logic [31:0]      mem_addr_wb;
    logic [4:0]       rd_num_wb;
    logic [1:0]       register_src_wb;
    logic             register_write_wb;
    logic             is_word_wb;
    // Element 0 occupies bits 31:24 (big-endian byte order).
    logic [0:3][7:0]  cache_data_out_wb;
    logic [1:0]       byte_number_wb;
    logic             halted_controller_wb;
    logic [4:0]       rs_num;
    logic [4:0]       rt_num;
    logic [31:0]      rs_data;
    logic [31:0]      rt_data;
    logic             halted;
    logic [31:0]      write_count;
    logic [31:0]      last_commit_pc;

    modport master (
        output inst_addr_wb, ALU_result_wb, mem_addr_wb, rd_num_wb, register_src_wb,
               register_write_wb, is_word_wb, cache_data_out_wb, byte_number_wb,
               halted_controller_wb, rs_num, rt_num,
        input  rs_data, rt_data, halted, write_count, last_commit_pc
    );

    modport slave (
        input  inst_addr_wb, ALU_result_wb, mem_addr_wb, rd_num_wb, register_src_wb,
               register_write_wb, is_word_wb, cache_data_out_wb, byte_number_wb,
               halted_controller_wb, rs_num, rt_num,
        output rs_data, rt_data, halted, write_count, last_commit_pc
    );
endinterface

// File: rtl/writeback_unit.sv
// Writeback stage: result select/format, 32x32 register file, bypassed reads, halt FSM.
// Latency: commit lands on the next rising edge; read ports are combinational with write-through bypass.
// Backpressure: none; every WB-stage instruction is consumed in one cycle (ignored once halted).
// Ports:
//   clk   : core clock, all state updates on the rising edge
//   rst_b : asynchronous active-low reset
//   wb    : writeback_unit_if.slave (MEM/WB inputs, decode read ports, status outputs)
module writeback_unit (
    input  logic              clk,
    input  logic              rst_b,
    writeback_unit_if.slave   wb
);

    localparam logic [1:0] SRC_ALU  = 2'd0;
    localparam logic [1:0] SRC_LOAD = 2'd1;
    localparam logic [1:0] SRC_LINK = 2'd2;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_t;

    state_t       state_q;
    state_t       state_d;

    logic [31:0]  regs [0:31];
    logic [31:0]  write_count_q;
    logic [31:0]  last_commit_pc_q;

    logic [7:0]   load_byte;
    logic [31:0]  load_value;
    logic [31:0]  result;
    logic         commit;

    // The effective address travels with the instruction for debug visibility only.
    logic         unused_mem_addr;
    assign unused_mem_addr = ^wb.mem_addr_wb;

    // ------------------------------------------------------------------
    // Result formatting
    // ------------------------------------------------------------------
    assign load_byte = wb.cache_data_out_wb[wb.byte_number_wb];

    always_comb begin
        load_value = {{24{load_byte[7]}}, load_byte};
        if (wb.is_word_wb) begin
            load_value = wb.cache_data_out_wb;
        end
    end

    always_comb begin
        result = wb.ALU_result_wb;
        case (wb.register_src_wb)
            SRC_ALU:  result = wb.ALU_result_wb;
            SRC_LOAD: result = load_value;
            SRC_LINK: result = wb.inst_addr_wb + 32'd4;
            default:  result = wb.ALU_result_wb;  // reserved select, never committed
        endcase
    end

    // ------------------------------------------------------------------
    // Halt FSM: next state and commit qualification
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        commit  = 1'b0;
        case (state_q)
            RUN: begin
                // A halting instruction still commits its own result on the edge
                // that freezes the core.
                commit = wb.register_write_wb
                         && (wb.rd_num_wb != 5'd0)
                         && (wb.register_src_wb != 2'd3);
                if (wb.halted_controller_wb) begin
                    state_d = HALTED;
                end
            end
            HALTED: begin
                state_d = HALTED;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Architectural state
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= 32'd0;
            end
            write_count_q    <= 32'd0;
            last_commit_pc_q <= 32'd0;
        end else if (commit) begin
            regs[wb.rd_num_wb] <= result;
            write_count_q      <= write_count_q + 32'd1;
            last_commit_pc_q   <= wb.inst_addr_wb;
        end
    end

    // ------------------------------------------------------------------
    // Read ports: r0 hard-wired to zero, then same-cycle bypass of the commit.
    // commit already excludes rd 0, so the bypass can never shadow r0.
    // ------------------------------------------------------------------
    always_comb begin
        wb.rs_data = regs[wb.rs_num];
        if (wb.rs_num == 5'd0) begin
            wb.rs_data = 32'd0;
        end else if (commit && (wb.rd_num_wb == wb.rs_num)) begin
            wb.rs_data = result;
        end
    end

    always_comb begin
        wb.rt_data = regs[wb.rt_num];
        if (wb.rt_num == 5'd0) begin
            wb.rt_data = 32'd0;
        end else if (commit && (wb.rd_num_wb == wb.rt_num)) begin
            wb.rt_data = result;
        end
    end

    assign wb.halted         = (state_q == HALTED);
    assign wb.write_count    = write_count_q;
    assign wb.last_commit_pc = last_commit_pc_q;

endmodule
